// File: rtl/dmem_access_ctrl_pkg.sv
// ============================================================================
//  Module   : dmem_access_ctrl_pkg
//  Brief    : Shared encodings for the MEM-stage data-memory sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_access_ctrl_pkg;

   // ResultSrc encodings used by the writeback mux
   localparam logic [1:0] c_RES_ALU = 2'b00;
   localparam logic [1:0] c_RES_MEM = 2'b01;
   localparam logic [1:0] c_RES_PC4 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
// ============================================================================
//  Module   : dmem_timeout_cnt
//  Brief    : WAIT-cycle counter; tc fires on the TIMEOUT_CYC-th enabled cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_timeout_cnt #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int                 c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   assign tc = enable & (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
//  Module   : dmem_access_ctrl
//  Brief    : MEM-stage req/ack sequencer for a variable-latency data memory.
//             Optional WAIT timeout enabled by defining DMEM_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter logic [1:0] LOAD_SRC    = c_RES_MEM,
   parameter int         TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [DATA_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              StallM,
   output logic              mem_fault
);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_access;
   logic   w_timeout;

   assign w_access = MemWriteM | (ResultSrcM == LOAD_SRC);
   assign StallM   = w_access & (r_state != ST_DONE);

`ifdef DMEM_TIMEOUT_EN
   localparam logic [DATA_W-1:0] c_FAULT_DATA = DATA_W'(32'hDEAD_BEEF);

   logic w_tc;
   logic r_fault;

   // Ack is excluded from enable so a coincident ack always wins
   dmem_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (r_state != ST_WAIT),
      .enable ((r_state == ST_WAIT) & ~dmem_ack),
      .tc     (w_tc)
   );

   assign w_timeout = w_tc;
   assign mem_fault = r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_timeout;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign mem_fault = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_access)             w_state_nxt = ST_WAIT;
         ST_WAIT: if (dmem_ack | w_timeout) w_state_nxt = ST_DONE;
         ST_DONE:                           w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         ReadDataM  <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_access) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= MemWriteM;
                  dmem_addr  <= ALUResultM;
                  dmem_wdata <= WriteDataM;
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) begin
                     ReadDataM <= dmem_rdata;
                  end
`ifdef DMEM_TIMEOUT_EN
               end else if (w_timeout) begin
                  dmem_req  <= 1'b0;
                  ReadDataM <= c_FAULT_DATA;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Brief    : Self-checking bench for dmem_access_ctrl (directed + random txns).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;
   import dmem_access_ctrl_pkg::*;

   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          MemWriteM;
   logic [1:0]    ResultSrcM;
   logic [DW-1:0] ALUResultM;
   logic [DW-1:0] WriteDataM;
   logic          dmem_req;
   logic          dmem_we;
   logic [DW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic [DW-1:0] ReadDataM;
   logic          StallM;
   logic          mem_fault;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_rd;

   always #5 clk = ~clk;

   dmem_access_ctrl #(
      .DATA_W      (DW),
      .LOAD_SRC    (c_RES_MEM),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .mem_fault  (mem_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 none, 1 load, 2 store, 3 store+load flags (treated as store)
   task automatic set_instr(input int kind, input logic [31:0] a, input logic [31:0] d);
      MemWriteM  = (kind >= 2);
      ResultSrcM = (kind == 1 || kind == 3) ? c_RES_MEM :
                   ($urandom_range(0, 1) != 0 ? c_RES_ALU : c_RES_PC4);
      ALUResultM = a;
      WriteDataM = d;
   endtask

   task automatic idle_cycle(input logic ack);
      set_instr(0, $urandom, $urandom);
      dmem_ack   = ack;
      dmem_rdata = $urandom;
      #1;
      chk("idle_stall", StallM, 0);
      chk("idle_req", dmem_req, 0);
      chk("idle_rdata", ReadDataM, exp_rd);
      chk("idle_fault", mem_fault, 0);
      tick();
   endtask

   // One memory access: detect cycle, `delay` WAIT cycles, then DONE.
   task automatic run_txn(input int kind, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay, input bit never_ack);
      logic exp_we;
      logic exp_fault;
      int   stalls;
      exp_we    = (kind >= 2);
      exp_fault = 1'b0;
      stalls    = 0;

      set_instr(kind, a, wd);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      #1;
      chk("det_stall", StallM, 1);
      chk("det_req", dmem_req, 0);
      chk("det_fault", mem_fault, 0);
      if (StallM === 1'b1) stalls++;
      tick();

      for (int i = 1; i <= delay; i++) begin
         dmem_ack   = (i == delay) && !never_ack;
         dmem_rdata = (i == delay) ? rd : $urandom;
         #1;
         chk("wait_req", dmem_req, 1);
         chk("wait_we", dmem_we, exp_we);
         chk("wait_addr", dmem_addr, a);
         chk("wait_wdata", dmem_wdata, wd);
         chk("wait_rdata_hold", ReadDataM, exp_rd);
         if (StallM === 1'b1) stalls++;
         tick();
      end

      if (never_ack) begin
         exp_rd    = 32'hDEAD_BEEF;
         exp_fault = 1'b1;
      end else if (kind == 1) begin
         exp_rd = rd;
      end

      dmem_ack   = $urandom_range(0, 1);
      dmem_rdata = $urandom;
      #1;
      chk("done_req", dmem_req, 0);
      chk("done_stall", StallM, 0);
      chk("done_rdata", ReadDataM, exp_rd);
      chk("done_fault", mem_fault, exp_fault);
      chk("stall_cycles", stalls, delay + 1);
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      exp_rd     = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_instr(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_stall", StallM, 0);
      chk("rst_fault", mem_fault, 0);
      reset = 1'b0;
      tick();

      // Load, ack on first WAIT cycle
      run_txn(1, 32'h100, 32'h0, 32'h1234_5678, 1, 1'b0);
      // Store, ack after 5 WAIT cycles
      run_txn(2, 32'h200, 32'hCAFE_F00D, 32'h5555_AAAA, 5, 1'b0);
      // Back-to-back load then store
      run_txn(1, 32'h300, 32'h0, 32'h0BAD_F00D, 2, 1'b0);
      run_txn(2, 32'h304, 32'h7777_8888, 32'h1111_2222, 3, 1'b0);
      // Both flags set behaves as a store
      run_txn(3, 32'h308, 32'hABCD_0123, 32'hFFFF_0000, 1, 1'b0);
      // Spurious ack with no access
      idle_cycle(1'b1);
      idle_cycle(1'b1);

      // Reset in the middle of a WAIT
      set_instr(2, 32'h400, 32'h4444_4444);
      dmem_ack = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b1;
      set_instr(0, 0, 0);
      #1;
      chk("midrst_req", dmem_req, 0);
      chk("midrst_stall", StallM, 0);
      chk("midrst_rdata", ReadDataM, 0);
      chk("midrst_fault", mem_fault, 0);
      exp_rd = '0;
      tick();
      reset = 1'b0;
      idle_cycle(1'b0);

      run_txn(1, 32'h500, 32'h0, 32'h5A5A_5A5A, 1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
      run_txn(1, 32'h600, 32'h0, 32'h0, TO, 1'b1);
      idle_cycle(1'b0);
      run_txn(1, 32'h604, 32'h0, 32'h6060_6060, TO, 1'b0);
`endif

      for (int n = 0; n < 24; n++) begin
         int          kind;
         int          gap;
         logic [31:0] a;
         logic [31:0] wd;
         logic [31:0] rd;
         kind = $urandom_range(1, 3);
         gap  = $urandom_range(0, 2);
         a    = $urandom;
         wd   = $urandom;
         rd   = $urandom;
         run_txn(kind, a, wd, rd, $urandom_range(1, 6), 1'b0);
         for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 1) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
